// File: rtl/wb_regfile.sv
// Writeback stage and 32-entry architectural register file with write-before-read
// bypass on both decode read ports, plus a last-commit record and saturating commit counter.
module wb_regfile #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] alu_data_in,
    input  logic [DATA_W-1:0] rd_in,
    input  logic [ADDR_W-1:0] rd_address_in,
    input  logic              RegWrite_in,
    input  logic              MemtoReg_in,
    input  logic [ADDR_W-1:0] rs1_addr,
    input  logic [ADDR_W-1:0] rs2_addr,
    output logic [DATA_W-1:0] rs1_data,
    output logic [DATA_W-1:0] rs2_data,
    output logic [DATA_W-1:0] wb_data,
    output logic              wb_valid,
    output logic [ADDR_W-1:0] last_wb_addr,
    output logic [DATA_W-1:0] last_wb_data,
    output logic              last_wb_valid,
    output logic [31:0]       wb_count
);

    localparam int NREG = 1 << ADDR_W;

    logic [DATA_W-1:0] regs_reg [NREG];
    logic [ADDR_W-1:0] last_wb_addr_reg;
    logic [DATA_W-1:0] last_wb_data_reg;
    logic              last_wb_valid_reg;
    logic [31:0]       wb_count_reg;

    assign wb_data  = MemtoReg_in ? rd_in : alu_data_in;
    assign wb_valid = RegWrite_in && (rd_address_in != '0) && reset;

    // x0 is only ever written by reset, so it always holds zero.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NREG; i++) begin
                regs_reg[i] <= '0;
            end
            last_wb_addr_reg  <= '0;
            last_wb_data_reg  <= '0;
            last_wb_valid_reg <= 1'b0;
            wb_count_reg      <= '0;
        end else if (wb_valid) begin
            regs_reg[rd_address_in] <= wb_data;
            last_wb_addr_reg        <= rd_address_in;
            last_wb_data_reg        <= wb_data;
            last_wb_valid_reg       <= 1'b1;
            if (wb_count_reg != '1) begin
                wb_count_reg <= wb_count_reg + 32'd1;
            end
        end
    end

    // Two identical read ports; each resolves x0, bypass and array read independently.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_port
            logic [ADDR_W-1:0] addr;
            logic [DATA_W-1:0] data;

            assign addr = (gi == 0) ? rs1_addr : rs2_addr;

            always_comb begin
                data = '0;
                if (reset && (addr != '0)) begin
                    if (wb_valid && (addr == rd_address_in)) begin
                        data = wb_data;
                    end else begin
                        data = regs_reg[addr];
                    end
                end
            end
        end
    endgenerate

    assign rs1_data      = g_port[0].data;
    assign rs2_data      = g_port[1].data;
    assign last_wb_addr  = last_wb_addr_reg;
    assign last_wb_data  = last_wb_data_reg;
    assign last_wb_valid = last_wb_valid_reg;
    assign wb_count      = wb_count_reg;

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against an array-based reference model.
module tb_wb_regfile;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] alu_data_in, rd_in;
    logic [4:0]  rd_address_in;
    logic        RegWrite_in, MemtoReg_in;
    logic [4:0]  rs1_addr, rs2_addr;
    logic [31:0] rs1_data, rs2_data, wb_data;
    logic        wb_valid;
    logic [4:0]  last_wb_addr;
    logic [31:0] last_wb_data;
    logic        last_wb_valid;
    logic [31:0] wb_count;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: architectural contents and commit history.
    logic [31:0] m_regs [32];
    logic [4:0]  m_last_addr;
    logic [31:0] m_last_data;
    logic        m_last_valid;
    logic [31:0] m_count;
    bit          m_known = 0;

    wb_regfile #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk           (clk),
        .reset         (reset),
        .alu_data_in   (alu_data_in),
        .rd_in         (rd_in),
        .rd_address_in (rd_address_in),
        .RegWrite_in   (RegWrite_in),
        .MemtoReg_in   (MemtoReg_in),
        .rs1_addr      (rs1_addr),
        .rs2_addr      (rs2_addr),
        .rs1_data      (rs1_data),
        .rs2_data      (rs2_data),
        .wb_data       (wb_data),
        .wb_valid      (wb_valid),
        .last_wb_addr  (last_wb_addr),
        .last_wb_data  (last_wb_data),
        .last_wb_valid (last_wb_valid),
        .wb_count      (wb_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [4:0] a, input logic commit,
                                               input logic [31:0] wbd);
        if (!reset || a == 5'd0) return 32'h0;
        if (commit && a == rd_address_in) return wbd;
        return m_regs[a];
    endfunction

    // Compare process: outputs are checked just before the edge, then the model takes the commit.
    always @(negedge clk) begin
        logic [31:0] exp_wbd;
        logic        exp_commit;
        exp_wbd    = MemtoReg_in ? rd_in : alu_data_in;
        exp_commit = RegWrite_in && (rd_address_in != 5'd0) && reset;
        if (m_known) begin
            $display("txn t=%0t rst=%b we=%b rd=%0d wbd=%h rs1=%0d:%h rs2=%0d:%h cnt=%h",
                     $time, reset, RegWrite_in, rd_address_in, wb_data,
                     rs1_addr, rs1_data, rs2_addr, rs2_data, wb_count);
            chk("wb_data", wb_data, exp_wbd);
            chk("wb_valid", {31'd0, wb_valid}, {31'd0, exp_commit});
            chk("rs1_data", rs1_data, model_read(rs1_addr, exp_commit, exp_wbd));
            chk("rs2_data", rs2_data, model_read(rs2_addr, exp_commit, exp_wbd));
            chk("last_wb_addr", {27'd0, last_wb_addr}, {27'd0, m_last_addr});
            chk("last_wb_data", last_wb_data, m_last_data);
            chk("last_wb_valid", {31'd0, last_wb_valid}, {31'd0, m_last_valid});
            chk("wb_count", wb_count, m_count);
        end
        if (!reset) begin
            for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
            m_last_addr  = 5'd0;
            m_last_data  = 32'h0;
            m_last_valid = 1'b0;
            m_count      = 32'h0;
            m_known      = 1;
        end else if (exp_commit) begin
            m_regs[rd_address_in] = exp_wbd;
            m_last_addr  = rd_address_in;
            m_last_data  = exp_wbd;
            m_last_valid = 1'b1;
            if (m_count != 32'hFFFF_FFFF) m_count = m_count + 32'd1;
        end
    end

    task automatic drive(input logic rst, input logic we, input logic mtr, input logic [4:0] rd,
                         input logic [31:0] alu, input logic [31:0] mem,
                         input logic [4:0] a1, input logic [4:0] a2);
        @(posedge clk);
        #1;
        reset         = rst;
        RegWrite_in   = we;
        MemtoReg_in   = mtr;
        rd_address_in = rd;
        alu_data_in   = alu;
        rd_in         = mem;
        rs1_addr      = a1;
        rs2_addr      = a2;
    endtask

    initial begin
        logic [4:0] rd_r;
        reset = 1'b0; RegWrite_in = 1'b1; MemtoReg_in = 1'b0; rd_address_in = 5'd3;
        alu_data_in = 32'h5555_5555; rd_in = 32'h0; rs1_addr = 5'd3; rs2_addr = 5'd0;

        // Reset held two cycles with a write pending to x3.
        drive(0, 1, 0, 5'd3, 32'h5555_5555, 32'h0, 5'd3, 5'd3);
        for (int i = 1; i < 32; i++) begin
            drive(1, 0, 0, 5'd3, 32'h0, 32'h0, i[4:0], 5'(32 - i));
            @(negedge clk);
            chk("reset_read", rs1_data, 32'h0);
            if (i == 1) begin
                chk("reset_count", wb_count, 32'h0);
                chk("reset_last_valid", {31'd0, last_wb_valid}, 32'h0);
            end
        end

        // Writeback mux and commit.
        drive(1, 1, 0, 5'd5, 32'h1111_1111, 32'h2222_2222, 5'd0, 5'd0);
        drive(1, 1, 1, 5'd6, 32'h1111_1111, 32'h2222_2222, 5'd0, 5'd0);
        drive(1, 0, 0, 5'd0, 32'h0, 32'h0, 5'd5, 5'd6);
        @(negedge clk);
        chk("mux_x5", rs1_data, 32'h1111_1111);
        chk("mux_x6", rs2_data, 32'h2222_2222);
        chk("mux_count", wb_count, 32'd2);
        chk("mux_last_addr", {27'd0, last_wb_addr}, 32'd6);

        // Same-cycle bypass on both ports.
        drive(1, 1, 0, 5'd7, 32'hAAAA_0000, 32'h0, 5'd0, 5'd0);
        drive(1, 1, 1, 5'd7, 32'h0, 32'hDEAD_BEEF, 5'd7, 5'd7);
        @(negedge clk);
        chk("bypass_rs1", rs1_data, 32'hDEAD_BEEF);
        chk("bypass_rs2", rs2_data, 32'hDEAD_BEEF);
        drive(1, 0, 0, 5'd0, 32'h0, 32'h0, 5'd7, 5'd7);
        @(negedge clk);
        chk("bypass_stored", rs1_data, 32'hDEAD_BEEF);

        // Write to x0 is discarded and not counted.
        drive(1, 1, 0, 5'd0, 32'hFFFF_FFFF, 32'h0, 5'd0, 5'd0);
        @(negedge clk);
        chk("x0_read", rs1_data, 32'h0);
        chk("x0_valid", {31'd0, wb_valid}, 32'h0);
        drive(1, 0, 0, 5'd9, 32'h1234_5678, 32'h0, 5'd9, 5'd0);
        @(negedge clk);
        chk("x0_count", wb_count, 32'd4);
        chk("x0_last_addr", {27'd0, last_wb_addr}, 32'd7);
        chk("nowrite_bypass", rs1_data, 32'h0);
        drive(1, 0, 0, 5'd0, 32'h0, 32'h0, 5'd9, 5'd0);
        @(negedge clk);
        chk("nowrite_x9", rs1_data, 32'h0);
        chk("nowrite_count", wb_count, 32'd4);

        // Randomized traffic, including occasional mid-stream reset.
        for (int n = 0; n < 600; n++) begin
            rd_r = 5'($urandom_range(0, 31));
            drive(($urandom_range(0, 59) != 0), ($urandom_range(0, 3) != 0), 1'($urandom),
                  rd_r, $urandom, $urandom,
                  ($urandom_range(0, 3) == 0) ? rd_r : 5'($urandom_range(0, 31)),
                  ($urandom_range(0, 3) == 0) ? rd_r : 5'($urandom_range(0, 31)));
        end

        // Saturation: preload the counter near its limit, then commit three times.
        drive(1, 0, 0, 5'd0, 32'h0, 32'h0, 5'd0, 5'd0);
        force dut.wb_count_reg = 32'hFFFF_FFFE;
        release dut.wb_count_reg;
        m_count = 32'hFFFF_FFFE;
        @(negedge clk);
        chk("sat_preload", wb_count, 32'hFFFF_FFFE);
        for (int k = 0; k < 3; k++) begin
            drive(1, 1, 0, 5'd10, 32'h100 + k, 32'h0, 5'd10, 5'd0);
        end
        drive(1, 0, 0, 5'd0, 32'h0, 32'h0, 5'd10, 5'd0);
        @(negedge clk);
        chk("sat_count", wb_count, 32'hFFFF_FFFF);
        chk("sat_x10", rs1_data, 32'h0000_0102);

        // Reset pulse during a commit drops the write and clears everything.
        drive(0, 1, 0, 5'd12, 32'h0000_0055, 32'h0, 5'd12, 5'd10);
        @(negedge clk);
        chk("rst_pulse_rs1", rs1_data, 32'h0);
        drive(1, 0, 0, 5'd0, 32'h0, 32'h0, 5'd12, 5'd10);
        @(negedge clk);
        chk("rst_x12", rs1_data, 32'h0);
        chk("rst_x10", rs2_data, 32'h0);
        chk("rst_count", wb_count, 32'h0);
        chk("rst_last_valid", {31'd0, last_wb_valid}, 32'h0);

        drive(1, 0, 0, 5'd0, 32'h0, 32'h0, 5'd0, 5'd0);
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_regfile.md
# wb_regfile

Writeback stage and architectural register file for the pipelined processor. The block takes the registered outputs of the MEM/WB pipeline register, selects the writeback value, and commits it to a 32 x 32-bit register file. It serves the two decode-stage read ports with write-before-read bypass. It also keeps a last-commit record and a commit counter, which the hazard/forwarding logic and the debug port use.

## Interface
- DATA_W, 32, register and datapath width
- ADDR_W, 5, register index width (2^ADDR_W registers)
- clk  input  1  rising-edge clock; the only clock
- reset  input  1  synchronous, active-low reset, sampled on rising clk
- alu_data_in  input  DATA_W  ALU result from MEM/WB
- rd_in  input  DATA_W  memory read data from MEM/WB
- rd_address_in  input  ADDR_W  destination register index from MEM/WB
- RegWrite_in  input  1  writeback enable from MEM/WB
- MemtoReg_in  input  1  1 = write rd_in, 0 = write alu_data_in
- rs1_addr, rs2_addr  input  ADDR_W  decode-stage read indices
- rs1_data, rs2_data  output  DATA_W  read data, combinational
- wb_data  output  DATA_W  selected writeback value, combinational, for forwarding
- wb_valid  output  1  combinational; RegWrite_in && rd_address_in != 0 && reset high
- last_wb_addr  output  ADDR_W  index of the most recent commit
- last_wb_data  output  DATA_W  value of the most recent commit
- last_wb_valid  output  1  at least one commit has happened since reset
- wb_count  output  32  count of commits since reset, saturating

## Operation
- Writeback value:
  - wb_data = MemtoReg_in ? rd_in : alu_data_in.
  - wb_data is driven regardless of RegWrite_in.
- Commit condition: wb_valid, i.e. RegWrite_in = 1, rd_address_in != 0, and reset high.
- Commit on a rising clk edge:
  - regs[rd_address_in] <= wb_data.
  - last_wb_addr <= rd_address_in; last_wb_data <= wb_data; last_wb_valid <= 1.
  - wb_count <= wb_count + 1, saturating at 32'hFFFF_FFFF (it holds, it does not wrap).
- Register x0:
  - Reads always return 0.
  - Writes to x0 are discarded.
  - A write to x0 does not count as a commit: wb_count and the last_* outputs are unchanged.
- Read ports:
  - rsN_data = 0 if rsN_addr = 0.
  - Otherwise, if wb_valid and rsN_addr == rd_address_in, rsN_data = wb_data (bypass).
  - Otherwise rsN_data = regs[rsN_addr].
  - Both ports resolve independently. rs1_addr == rs2_addr is legal and returns identical data.
- While reset is low:
  - rs1_data, rs2_data and wb_valid are forced to 0.
  - No commit occurs.

## Timing
- Reset:
  - On a rising edge with reset = 0, all regs, last_wb_addr, last_wb_data, last_wb_valid and wb_count clear to 0.
  - A commit requested in that same cycle is dropped.
  - Reset asserted mid-stream behaves the same way: state is cleared at the first sampled edge and pending writebacks are lost.
- Write latency: a value is architecturally stored at the edge ending the cycle in which it was presented. It is visible through the read ports in that same cycle via the bypass, with zero-cycle read-after-write.
- Read latency: 0 cycles (combinational), so there is no handshake and no backpressure. The block accepts one writeback every cycle.
- last_* and wb_count update 1 cycle after the commit cycle.
- Same index written on back-to-back cycles: the later write wins. Each write increments wb_count.
- Saturation: at wb_count = 32'hFFFF_FFFE, two further commits yield FFFF_FFFF and then FFFF_FFFF.

## Test plan
- Reset: hold reset = 0 for 2 cycles with RegWrite_in = 1, rd_address_in = 3 -> after release, all 31 reads return 0, wb_count = 0, last_wb_valid = 0.
- Mux and commit:
  - Cycle A: alu_data_in = 32'h1111_1111, rd_in = 32'h2222_2222, MemtoReg_in = 0, rd_address_in = 5, RegWrite_in = 1.
  - Cycle B: MemtoReg_in = 1, rd_address_in = 6.
  - Required: reading x5 = 32'h1111_1111 and x6 = 32'h2222_2222; wb_count = 2; last_wb_addr = 6.
- Bypass: x7 holds 32'hAAAA_0000. Present a write of 32'hDEAD_BEEF to x7 with rs1_addr = rs2_addr = 7 -> both ports read 32'hDEAD_BEEF in that same cycle, and x7 holds it afterwards.
- x0: RegWrite_in = 1, rd_address_in = 0, wb_data = 32'hFFFF_FFFF -> x0 reads 0, wb_valid = 0, wb_count and last_* unchanged.
- No write: RegWrite_in = 0 with rd_address_in = 9 -> x9 is unchanged, there is no bypass on x9, and wb_count is unchanged.
- Saturation and mid-run reset:
  - Force wb_count to FFFF_FFFE and commit 3 times -> wb_count stays at FFFF_FFFF.
  - Then pulse reset low for 1 cycle during a commit -> the write is dropped and everything reads 0.
